ifetch_unit: RTL

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit_pkg.sv | 27 ++
 rtl/ifetch_unit_if_id_reg.sv | 53 +++++
 rtl/ifetch_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared pipeline definitions for the instruction fetch stage.
//   fetch_state_e : fetch FSM states (FETCH, MISS, HALT)
//   ifid_ctrl_e   : IF/ID register action (hold, load, bubble)
//   HLT_OPC_DEF   : default opcode (instr[15:12]) that halts fetch
//   NOP_INSTR_DEF : default instruction word placed in IF/ID when invalid
package ifetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    MISS  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_ctrl_e;

  localparam logic [3:0]  HLT_OPC_DEF   = 4'hF;
  localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;

  function automatic logic is_halt(input logic [15:0] word, input logic [3:0] opc);
    return (word[15:12] == opc);
  endfunction

endpackage

// File: rtl/ifetch_unit_if_id_reg.sv
// IF/ID pipeline register with hold / load / bubble control.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   ctrl              : IFID_HOLD keeps contents, IFID_LOAD captures instr/pc1,
//                       IFID_BUBBLE invalidates and inserts NOP_INSTR
//   instr, pc1        : fetched instruction word and its PC+1
//   if_id_instr/pc1/valid : registered outputs toward decode
module if_id_reg
  import ifetch_unit_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  ifid_ctrl_e  ctrl,
  input  logic [15:0] instr,
  input  logic [15:0] pc1,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc1,
  output logic        if_id_valid
);

  logic [15:0] instr_p1;
  logic [15:0] pc1_p1;
  logic        vld_p1;

  // IF -> ID stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_p1 <= NOP_INSTR;
      pc1_p1   <= 16'h0000;
      vld_p1   <= 1'b0;
    end else begin
      case (ctrl)
        IFID_LOAD: begin
          instr_p1 <= instr;
          pc1_p1   <= pc1;
          vld_p1   <= 1'b1;
        end
        IFID_BUBBLE: begin
          instr_p1 <= NOP_INSTR;
          vld_p1   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign if_id_instr = instr_p1;
  assign if_id_pc1   = pc1_p1;
  assign if_id_valid = vld_p1;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC register, fetch FSM (FETCH/MISS/HALT) and the
// IF/ID register. Handles I-cache misses, decode stalls, EX redirects
// (including redirects that arrive while a miss is outstanding) and halting.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_addr       : fetch address (the PC register)
//   instr, i_rdy : instruction word and fetch-complete from memory
//   stall_if     : decode hazard, hold PC and IF/ID
//   flush        : redirect to br_target (overrides stall_if)
//   if_id_*      : registered instruction, PC+1 and valid toward decode
//   hlt          : fetch halted on HLT_OPC
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter logic [3:0]  HLT_OPC   = HLT_OPC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] i_addr,
  input  logic [15:0] instr,
  input  logic        i_rdy,
  input  logic        stall_if,
  input  logic        flush,
  input  logic [15:0] br_target,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc1,
  output logic        if_id_valid,
  output logic        hlt
);

  fetch_state_e state, state_n;
  logic [15:0]  pc, pc_n;
  logic         redir_pend, redir_pend_n;
  logic [15:0]  redir_pc, redir_pc_n;
  ifid_ctrl_e   ifid_ctrl;

  // PC / FSM stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      redir_pend <= 1'b0;
      redir_pc   <= 16'h0000;
      hlt        <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      redir_pend <= redir_pend_n;
      redir_pc   <= redir_pc_n;
      hlt        <= (state_n == HALT);
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    redir_pend_n = redir_pend;
    redir_pc_n   = redir_pc;
    ifid_ctrl    = IFID_HOLD;
    case (state)
      HALT: begin
        // A flush means the halt was on a mispredicted path.
        if (flush) begin
          pc_n      = br_target;
          state_n   = FETCH;
          ifid_ctrl = IFID_BUBBLE;
        end else if (!stall_if) begin
          ifid_ctrl = IFID_BUBBLE;
        end
      end
      default: begin
        if (!i_rdy) begin
          // The address must stay put until memory answers, so a redirect
          // is remembered and applied once the outstanding fetch completes.
          state_n = MISS;
          if (flush) begin
            redir_pend_n = 1'b1;
            redir_pc_n   = br_target;
            ifid_ctrl    = IFID_BUBBLE;
          end else if (!stall_if) begin
            ifid_ctrl = IFID_BUBBLE;
          end
        end else if (flush || redir_pend) begin
          pc_n         = flush ? br_target : redir_pc;
          redir_pend_n = 1'b0;
          state_n      = FETCH;
          ifid_ctrl    = IFID_BUBBLE;
        end else if (!stall_if) begin
          ifid_ctrl = IFID_LOAD;
          if (is_halt(instr, HLT_OPC)) begin
            state_n = HALT;
          end else begin
            pc_n    = pc + 16'd1;
            state_n = FETCH;
          end
        end else begin
          state_n = FETCH;
        end
      end
    endcase
  end

  assign i_addr = pc;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctrl       (ifid_ctrl),
    .instr      (instr),
    .pc1        (pc + 16'd1),
    .if_id_instr(if_id_instr),
    .if_id_pc1  (if_id_pc1),
    .if_id_valid(if_id_valid)
  );

endmodule
